ttt_token_accumulator: RTL and testbench
========================================

TTT_TOKEN_ACCUMULATOR -- requirements
Module: ttt_token_accumulator

Interface
REQ-001 SHALL have parameter NEW_TOKENS_BITS, default 8: width of each per-neuron token count.
REQ-002 SHALL have parameter NUM_PROCESSORS, default 10: number of neurons; ID_BITS = $clog2(NUM_PROCESSORS).
REQ-003 SHALL have port clock_fast, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input token event is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the event this cycle.
REQ-007 SHALL have port in_target, input, ID_BITS: destination neuron of the event.
REQ-008 SHALL have port in_good, input, 1 bit: 1 = good tokens, 0 = bad tokens.
REQ-009 SHALL have port in_amount, input, NEW_TOKENS_BITS: number of tokens carried by the event.
REQ-010 SHALL have port sweep_start, input, 1 bit: pulse requesting one readout sweep.
REQ-011 SHALL have port neuron_id, output, ID_BITS: neuron currently presented to the processor core.
REQ-012 SHALL have port new_good_tokens, output, NEW_TOKENS_BITS: accumulated good tokens for neuron_id.
REQ-013 SHALL have port new_bad_tokens, output, NEW_TOKENS_BITS: accumulated bad tokens for neuron_id.
REQ-014 SHALL have port hold, output, 1 bit: 1 = processor core must not update; 0 = presented data is valid.
REQ-015 SHALL have port sweep_done, output, 1 bit: one-cycle pulse marking sweep completion.
REQ-016 SHALL have port drop, output, 1 bit: one-cycle pulse when an accepted event is discarded.

Function
REQ-017 SHALL hold two NUM_PROCESSORS-entry arrays, good_acc and bad_acc, each NEW_TOKENS_BITS wide.
REQ-018 SHALL drive in_ready = 1 in every cycle in which reset is low; an event is accepted when in_valid && in_ready.
REQ-019 SHALL, on acceptance with in_target < NUM_PROCESSORS, add in_amount to good_acc[in_target] if in_good=1, otherwise to bad_acc[in_target], saturating at 2^NEW_TOKENS_BITS-1.
REQ-020 SHALL, on acceptance with in_target >= NUM_PROCESSORS, leave both arrays unchanged and assert drop for exactly the next cycle.
REQ-021 SHALL implement the FSM states IDLE, SWEEP, and DONE.
REQ-022 SHALL, in IDLE with sweep_start=1, clear the index idx to 0 and enter SWEEP; sweep_start is ignored in SWEEP and DONE.
REQ-023 SHALL, in each SWEEP cycle, register neuron_id<=idx, new_good_tokens<=good_acc[idx], new_bad_tokens<=bad_acc[idx] and hold<=0, then clear both entries at idx.
REQ-024 SHALL increment idx after each SWEEP cycle and, after idx = NUM_PROCESSORS-1, enter DONE.
REQ-025 SHALL, in DONE, register hold<=1 and sweep_done<=1 for one cycle, then return to IDLE.
REQ-026 SHALL produce one-cycle output latency: hold is low for exactly NUM_PROCESSORS consecutive cycles, starting the cycle after the SWEEP entry edge, with neuron_id going 0,1,...,NUM_PROCESSORS-1.
REQ-027 SHALL, when an accepted event targets the entry being read out in the same cycle, output the pre-event value and store the entry as clear-then-add, so the new value equals min(in_amount, max).
REQ-028 SHALL keep accepting events into all other entries during SWEEP with no loss.
REQ-029 SHALL hold neuron_id, new_good_tokens and new_bad_tokens at their last values while hold=1.

Reset
REQ-030 SHALL, on reset, clear all accumulator entries, set state to IDLE and idx to 0.
REQ-031 SHALL, on reset, set neuron_id=0, new_good_tokens=0, new_bad_tokens=0, hold=1, sweep_done=0, drop=0 and in_ready=0.
REQ-032 SHALL make a reset asserted mid-sweep abort the sweep with no sweep_done pulse, and discard any event offered in that cycle.

Verification
REQ-033 SHALL pass: events (3,good,5),(3,good,7),(3,bad,2), then sweep_start -> at neuron_id=3: good=12, bad=2; all other neurons 0; sweep_done one cycle after neuron_id=9.
REQ-034 SHALL pass: events (1,good,200),(1,good,100) -> good=255 (saturated).
REQ-035 SHALL pass: event (12,good,4) -> drop pulses once; a following sweep shows all counts 0.
REQ-036 SHALL pass: during a sweep, event (5,good,9) in the cycle neuron 5 is read, with prior good=4 -> output good=4; the next sweep shows good=9.
REQ-037 SHALL pass: a second sweep_start mid-sweep -> ignored, with exactly 10 hold-low cycles.
REQ-038 SHALL pass: reset at neuron_id=4 -> hold=1 and no sweep_done; a subsequent sweep shows all counts 0.

Source files
------------

// File: rtl/ttt_token_accumulator.sv
// rtl/ttt_token_accumulator.sv - per-neuron good/bad token accumulator with readout sweep
//
// Purpose:
//   Accumulates token events into per-neuron good/bad counters (saturating).
//   Presents each neuron's totals to a processor core during a readout sweep
//   and clears each entry as it is read.
//
// Ports:
//   clock_fast      in   single clock, rising edge
//   reset           in   synchronous, active-high reset
//   in_valid        in   token event offered
//   in_ready        out  event accepted this cycle (high whenever reset is low)
//   in_target       in   destination neuron of the event
//   in_good         in   1 = good tokens, 0 = bad tokens
//   in_amount       in   token count carried by the event
//   sweep_start     in   request one readout sweep (honoured only in IDLE)
//   neuron_id       out  neuron currently presented
//   new_good_tokens out  accumulated good tokens for neuron_id
//   new_bad_tokens  out  accumulated bad tokens for neuron_id
//   hold            out  1 = core must not update, 0 = presented data valid
//   sweep_done      out  one-cycle pulse at sweep completion
//   drop            out  one-cycle pulse when an accepted event is discarded

module ttt_token_accumulator #(
   parameter int NEW_TOKENS_BITS = 8,
   parameter int NUM_PROCESSORS  = 10,
   localparam int ID_BITS = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
   input  logic                       clock_fast,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ID_BITS-1:0]         in_target,
   input  logic                       in_good,
   input  logic [NEW_TOKENS_BITS-1:0] in_amount,
   input  logic                       sweep_start,
   output logic [ID_BITS-1:0]         neuron_id,
   output logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
   output logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
   output logic                       hold,
   output logic                       sweep_done,
   output logic                       drop
);

   localparam logic [NEW_TOKENS_BITS-1:0] ZERO    = '0;
   localparam logic [NEW_TOKENS_BITS-1:0] MAX     = '1;
   localparam logic [ID_BITS-1:0]         LAST_ID = ID_BITS'(NUM_PROCESSORS - 1);
   localparam logic [ID_BITS:0]           NUM_EXT = (ID_BITS + 1)'(NUM_PROCESSORS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [ID_BITS-1:0]         idx;
   logic [NEW_TOKENS_BITS-1:0] good_acc [NUM_PROCESSORS];
   logic [NEW_TOKENS_BITS-1:0] bad_acc  [NUM_PROCESSORS];
   logic [NEW_TOKENS_BITS-1:0] good_nx  [NUM_PROCESSORS];
   logic [NEW_TOKENS_BITS-1:0] bad_nx   [NUM_PROCESSORS];
   logic [NEW_TOKENS_BITS-1:0] rd_good;
   logic [NEW_TOKENS_BITS-1:0] rd_bad;

   logic accept;
   logic target_ok;
   logic rd_en;
   logic done_en;

   function automatic logic [NEW_TOKENS_BITS-1:0] sat_add(
      input logic [NEW_TOKENS_BITS-1:0] a,
      input logic [NEW_TOKENS_BITS-1:0] b
   );
      logic [NEW_TOKENS_BITS:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[NEW_TOKENS_BITS] ? MAX : sum[NEW_TOKENS_BITS-1:0];
   endfunction

   // Events are taken unconditionally outside reset; nothing back-pressures.
   assign in_ready  = ~reset;
   assign accept    = in_valid & in_ready;
   assign target_ok = ({1'b0, in_target} < NUM_EXT);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock_fast) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (sweep_start) state_nx = S_SWEEP;
         S_SWEEP: if (idx == LAST_ID) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      rd_en   = 1'b0;
      done_en = 1'b0;
      case (state)
         S_SWEEP: rd_en   = 1'b1;
         S_DONE:  done_en = 1'b1;
         default: ;
      endcase
   end

   // Sweep index: cleared on sweep entry, advanced once per readout cycle.
   always_ff @(posedge clock_fast) begin
      if (reset) begin
         idx <= '0;
      end else if (state == S_IDLE && sweep_start) begin
         idx <= '0;
      end else if (rd_en) begin
         idx <= (idx == LAST_ID) ? '0 : idx + 1'b1;
      end
   end

   // Readout mux of the pre-event stored value at idx.
   always_comb begin
      rd_good = ZERO;
      rd_bad  = ZERO;
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
         if (idx == ID_BITS'(i)) begin
            rd_good = good_acc[i];
            rd_bad  = bad_acc[i];
         end
      end
   end

   // Next accumulator values. An entry being read is cleared first, then any
   // same-cycle event is added, so a colliding event is not lost.
   always_comb begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
         logic clr;
         logic hit;
         clr = rd_en && (idx == ID_BITS'(i));
         hit = accept && target_ok && (in_target == ID_BITS'(i));
         good_nx[i] = sat_add(clr ? ZERO : good_acc[i], (hit &&  in_good) ? in_amount : ZERO);
         bad_nx[i]  = sat_add(clr ? ZERO : bad_acc[i],  (hit && !in_good) ? in_amount : ZERO);
      end
   end

   // Accumulators and registered outputs.
   always_ff @(posedge clock_fast) begin
      if (reset) begin
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            good_acc[i] <= ZERO;
            bad_acc[i]  <= ZERO;
         end
         neuron_id       <= '0;
         new_good_tokens <= ZERO;
         new_bad_tokens  <= ZERO;
         hold            <= 1'b1;
         sweep_done      <= 1'b0;
         drop            <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            good_acc[i] <= good_nx[i];
            bad_acc[i]  <= bad_nx[i];
         end
         drop       <= accept && !target_ok;
         sweep_done <= done_en;
         if (rd_en) begin
            neuron_id       <= idx;
            new_good_tokens <= rd_good;
            new_bad_tokens  <= rd_bad;
            hold            <= 1'b0;
         end else if (done_en) begin
            hold <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ttt_token_accumulator.sv
// tb/tb_ttt_token_accumulator.sv - self-checking bench for ttt_token_accumulator

module tb_ttt_token_accumulator;

   localparam int NP = 10;
   localparam int W  = 8;
   localparam int IB = 4;

   logic          clock_fast = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IB-1:0] in_target = '0;
   logic          in_good = 1'b0;
   logic [W-1:0]  in_amount = '0;
   logic          sweep_start = 1'b0;
   logic [IB-1:0] neuron_id;
   logic [W-1:0]  new_good_tokens;
   logic [W-1:0]  new_bad_tokens;
   logic          hold;
   logic          sweep_done;
   logic          drop;

   int checks = 0;
   int errors = 0;
   int eg [NP];
   int eb [NP];

   typedef struct {
      int tgt;
      bit good;
      int amt;
      bit exp_drop;
   } ev_t;

   ev_t vec [10];

   ttt_token_accumulator #(
      .NEW_TOKENS_BITS(W),
      .NUM_PROCESSORS(NP)
   ) dut (
      .clock_fast(clock_fast),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_target(in_target),
      .in_good(in_good),
      .in_amount(in_amount),
      .sweep_start(sweep_start),
      .neuron_id(neuron_id),
      .new_good_tokens(new_good_tokens),
      .new_bad_tokens(new_bad_tokens),
      .hold(hold),
      .sweep_done(sweep_done),
      .drop(drop)
   );

   always #5 clock_fast = ~clock_fast;

   task automatic tick();
      @(posedge clock_fast);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NP; i++) begin
         eg[i] = 0;
         eb[i] = 0;
      end
   endtask

   task automatic send(input int tgt, input bit good, input int amt, input bit exp_drop);
      in_valid  = 1'b1;
      in_target = IB'(tgt);
      in_good   = good;
      in_amount = W'(amt);
      tick();
      in_valid = 1'b0;
      check($sformatf("drop_t%0d", tgt), {31'b0, drop}, {31'b0, exp_drop});
      tick();
      check("drop_clear", {31'b0, drop}, 32'd0);
   endtask

   // Runs one sweep against eg/eb. Optional: an event injected before the edge
   // that reads idx inj_at, a redundant sweep_start before the edge reading
   // idx restart_at, and a reset right after neuron abort_at is presented.
   task automatic run_sweep(input int inj_at, input int it, input bit ig, input int ia,
                            input int restart_at, input int abort_at);
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      check("entry_hold", {31'b0, hold}, 32'd1);
      for (int k = 0; k < NP; k++) begin
         if (k == inj_at) begin
            in_valid  = 1'b1;
            in_target = IB'(it);
            in_good   = ig;
            in_amount = W'(ia);
         end
         if (k == restart_at) sweep_start = 1'b1;
         tick();
         in_valid    = 1'b0;
         sweep_start = 1'b0;
         check($sformatf("hold_low_%0d", k), {31'b0, hold}, 32'd0);
         check($sformatf("nid_%0d", k), {28'b0, neuron_id}, k);
         check($sformatf("good_%0d", k), {24'b0, new_good_tokens}, eg[k]);
         check($sformatf("bad_%0d", k), {24'b0, new_bad_tokens}, eb[k]);
         check($sformatf("done_early_%0d", k), {31'b0, sweep_done}, 32'd0);
         if (k == abort_at) begin
            reset     = 1'b1;
            in_valid  = 1'b1;
            in_target = IB'(k);
            in_good   = 1'b1;
            in_amount = W'(50);
            tick();
            check("abort_hold", {31'b0, hold}, 32'd1);
            check("abort_ready", {31'b0, in_ready}, 32'd0);
            check("abort_done", {31'b0, sweep_done}, 32'd0);
            reset    = 1'b0;
            in_valid = 1'b0;
            for (int j = 0; j < 3; j++) begin
               tick();
               check("abort_no_done", {31'b0, sweep_done}, 32'd0);
               check("abort_hold_stays", {31'b0, hold}, 32'd1);
            end
            return;
         end
      end
      tick();
      check("done_pulse", {31'b0, sweep_done}, 32'd1);
      check("done_hold", {31'b0, hold}, 32'd1);
      check("done_nid_held", {28'b0, neuron_id}, NP - 1);
      check("done_good_held", {24'b0, new_good_tokens}, eg[NP-1]);
      tick();
      check("done_clear", {31'b0, sweep_done}, 32'd0);
      check("idle_hold", {31'b0, hold}, 32'd1);
   endtask

   initial begin
      vec[0] = '{3,  1'b1, 5,   1'b0};
      vec[1] = '{3,  1'b1, 7,   1'b0};
      vec[2] = '{3,  1'b0, 2,   1'b0};
      vec[3] = '{1,  1'b1, 200, 1'b0};
      vec[4] = '{1,  1'b1, 100, 1'b0};
      vec[5] = '{12, 1'b1, 4,   1'b1};
      vec[6] = '{15, 1'b0, 9,   1'b1};
      vec[7] = '{9,  1'b0, 255, 1'b0};
      vec[8] = '{9,  1'b0, 1,   1'b0};
      vec[9] = '{0,  1'b1, 0,   1'b0};

      // Reset values
      tick();
      tick();
      check("rst_ready", {31'b0, in_ready}, 32'd0);
      check("rst_hold", {31'b0, hold}, 32'd1);
      check("rst_done", {31'b0, sweep_done}, 32'd0);
      check("rst_drop", {31'b0, drop}, 32'd0);
      check("rst_nid", {28'b0, neuron_id}, 32'd0);
      check("rst_good", {24'b0, new_good_tokens}, 32'd0);
      check("rst_bad", {24'b0, new_bad_tokens}, 32'd0);
      reset = 1'b0;
      #1;
      check("ready_up", {31'b0, in_ready}, 32'd1);
      tick();

      // Event table, then sweep: hand-computed totals
      for (int v = 0; v < 10; v++) send(vec[v].tgt, vec[v].good, vec[v].amt, vec[v].exp_drop);
      clear_exp();
      eg[1] = 255;
      eg[3] = 12;
      eb[3] = 2;
      eb[9] = 255;
      run_sweep(-1, 0, 1'b0, 0, -1, -1);

      // Entries were cleared by the sweep (dropped events never landed)
      clear_exp();
      run_sweep(-1, 0, 1'b0, 0, -1, -1);

      // Event colliding with the entry being read
      send(5, 1'b1, 4, 1'b0);
      clear_exp();
      eg[5] = 4;
      run_sweep(5, 5, 1'b1, 9, -1, -1);

      // Next sweep shows 9; an event to a later entry lands in this sweep;
      // a redundant sweep_start mid-sweep is ignored
      clear_exp();
      eg[5] = 9;
      eg[7] = 6;
      run_sweep(5, 7, 1'b1, 6, 3, -1);
      tick();
      check("no_restart_hold", {31'b0, hold}, 32'd1);
      check("no_restart_done", {31'b0, sweep_done}, 32'd0);

      clear_exp();
      run_sweep(-1, 0, 1'b0, 0, -1, -1);

      // Reset mid-sweep at neuron 4
      send(4, 1'b1, 3, 1'b0);
      send(8, 1'b0, 11, 1'b0);
      clear_exp();
      eg[4] = 3;
      eb[8] = 11;
      run_sweep(-1, 0, 1'b0, 0, -1, 4);
      clear_exp();
      run_sweep(-1, 0, 1'b0, 0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
